// File: rtl/shot_scheduler.sv
// shot_scheduler
//   Sequences the shot pool. A rising edge of the fire button (while enabled)
//   becomes a single one-cycle, one-hot deploy pulse aimed at the
//   lowest-index idle slot. The scheduler then waits for that slot's
//   isActive, counts the shot, and holds off further shots for a number of
//   VGA frames.
//
// Ports
//   clk           system clock
//   resetN        asynchronous active-low reset
//   startOfFrame  one-cycle pulse per VGA frame (drives the cooldown)
//   shoot         fire button level, synchronised, active-high
//   enable        gameplay enable; low suppresses presses and drops pending
//   shots_active  per-slot isActive from the shot engines
//   deploy_shot   one-hot, one-cycle deploy pulse (registered)
//   busy          high whenever the sequencer is not idle
//   denied        one-cycle pulse: press dropped, every slot was busy
//   ack_error     one-cycle pulse: the slot never reported active
//   shots_fired   saturating count of acknowledged shots
//   state_dbg     current sequencer state (IDLE=0 ISSUE=1 WAIT_ACK=2 COOLDOWN=3)
//
// Handshake: there is no ready/valid pair here. A deploy is "accepted" only
// when shots_active[slot] is seen high while waiting; anything else on
// shots_active is ignored for that sequence.

module shot_scheduler #(
  parameter int NUM_SHOTS       = 8,
  parameter int COOLDOWN_FRAMES = 6,
  parameter int ACK_TIMEOUT     = 15
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 shoot,
  input  logic                 enable,
  input  logic [NUM_SHOTS-1:0] shots_active,
  output logic [NUM_SHOTS-1:0] deploy_shot,
  output logic                 busy,
  output logic                 denied,
  output logic                 ack_error,
  output logic [15:0]          shots_fired,
  output logic [1:0]           state_dbg
);

  localparam int SLOT_W = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
  localparam int FC_W   = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  state_t               state_q;
  logic                 shoot_q;
  logic                 pending_q;
  logic [SLOT_W-1:0]    slot_q;
  logic [7:0]           ack_cnt_q;
  logic [FC_W-1:0]      frame_cnt_q;
  logic [NUM_SHOTS-1:0] deploy_q;
  logic                 denied_q;
  logic                 ack_error_q;
  logic [15:0]          fired_q;
  logic [15:0]          fired_d;

  logic                 press;
  logic                 request;
  logic                 free_any;
  logic [SLOT_W-1:0]    free_idx;
  logic [NUM_SHOTS-1:0] free_onehot;

  assign press    = shoot & ~shoot_q & enable;
  // A stored press is only honoured while gameplay is enabled.
  assign request  = press | (pending_q & enable);
  assign free_any = ~&shots_active;
  assign fired_d  = (fired_q == 16'hFFFF) ? fired_q : fired_q + 16'd1;

  // Lowest-index idle slot: scan from the top so the lowest hit wins.
  always_comb begin
    free_idx    = '0;
    free_onehot = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!shots_active[i]) begin
        free_idx       = SLOT_W'(i);
        free_onehot    = '0;
        free_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      shoot_q     <= 1'b0;
      pending_q   <= 1'b0;
      slot_q      <= '0;
      ack_cnt_q   <= '0;
      frame_cnt_q <= '0;
      deploy_q    <= '0;
      denied_q    <= 1'b0;
      ack_error_q <= 1'b0;
      fired_q     <= '0;
    end else begin
      shoot_q     <= shoot;
      deploy_q    <= '0;
      denied_q    <= 1'b0;
      ack_error_q <= 1'b0;

      // One-deep press memory while a sequence is in flight.
      if (!enable) begin
        pending_q <= 1'b0;
      end else if (press && (state_q != S_IDLE)) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (request) begin
            pending_q <= 1'b0;
            if (free_any) begin
              slot_q   <= free_idx;
              // Pulse is registered here so it lines up with the ISSUE cycle.
              deploy_q <= free_onehot;
              state_q  <= S_ISSUE;
            end else begin
              denied_q <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          ack_cnt_q <= 8'(ACK_TIMEOUT);
          state_q   <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          // The cooldown load happens on this transition, so a frame pulse
          // arriving in the same cycle is not counted.
          if (shots_active[slot_q]) begin
            fired_q     <= fired_d;
            frame_cnt_q <= FC_W'(COOLDOWN_FRAMES);
            state_q     <= S_COOLDOWN;
          end else if (ack_cnt_q <= 8'd1) begin
            ack_error_q <= 1'b1;
            frame_cnt_q <= FC_W'(COOLDOWN_FRAMES);
            state_q     <= S_COOLDOWN;
          end else begin
            ack_cnt_q <= ack_cnt_q - 8'd1;
          end
        end

        S_COOLDOWN: begin
          if (frame_cnt_q == '0) begin
            state_q <= S_IDLE;
          end else if (startOfFrame) begin
            frame_cnt_q <= frame_cnt_q - FC_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign deploy_shot = deploy_q;
  assign busy        = (state_q != S_IDLE);
  assign denied      = denied_q;
  assign ack_error   = ack_error_q;
  assign shots_fired = fired_q;
  assign state_dbg   = state_q;

  a_deploy_onehot0: assert property (@(posedge clk) disable iff (!resetN)
    $onehot0(deploy_shot));
  a_deploy_in_issue: assert property (@(posedge clk) disable iff (!resetN)
    (deploy_shot != '0) |-> (state_q == S_ISSUE));
  a_denied_xor_err: assert property (@(posedge clk) disable iff (!resetN)
    !(denied && ack_error));

endmodule

// File: tb/tb_shot_scheduler.sv
// Testbench for shot_scheduler: default build (6-frame cooldown) plus a
// second instance built with no cooldown.
module tb_shot_scheduler;

  localparam int N  = 8;
  localparam int CD = 6;
  localparam int TO = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetN;
  logic          sof, shoot, enable;
  logic [N-1:0]  act;
  logic [N-1:0]  deploy;
  logic          busy, denied, ack_error;
  logic [15:0]   fired;
  logic [1:0]    st;

  logic          sof0, shoot0;
  logic [N-1:0]  act0;
  logic [N-1:0]  deploy0;
  logic          busy0, denied0, err0;
  logic [15:0]   fired0;
  logic [1:0]    st0;

  shot_scheduler #(.NUM_SHOTS(N), .COOLDOWN_FRAMES(CD), .ACK_TIMEOUT(TO)) u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .shoot(shoot), .enable(enable),
    .shots_active(act), .deploy_shot(deploy), .busy(busy), .denied(denied),
    .ack_error(ack_error), .shots_fired(fired), .state_dbg(st)
  );

  shot_scheduler #(.NUM_SHOTS(N), .COOLDOWN_FRAMES(0), .ACK_TIMEOUT(TO)) u_dut0 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof0), .shoot(shoot0), .enable(enable),
    .shots_active(act0), .deploy_shot(deploy0), .busy(busy0), .denied(denied0),
    .ack_error(err0), .shots_fired(fired0), .state_dbg(st0)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int deploy_cnt = 0;
  int denied_cnt = 0;
  int err_cnt    = 0;
  logic [15:0]  exp_fired  = '0;
  logic [15:0]  exp_fired0 = '0;
  logic [N-1:0] exp_q[$];

  // Pulse counters for the default instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (deploy != '0) deploy_cnt++;
    if (denied)       denied_cnt++;
    if (ack_error)    err_cnt++;
  end

  // ---------------- reference model ----------------
  // Target of a press: the lowest-numbered idle slot, or nothing if all busy.
  function automatic logic [N-1:0] model_pick(input logic [N-1:0] a);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (!a[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] model_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single-cycle button press; returns just after the edge that samples it.
  task automatic press();
    shoot = 1'b1;
    step(1);
    shoot = 1'b0;
  endtask

  // Feeds 'frames' frame pulses with gaps and checks busy only falls one
  // cycle after the last of them has been consumed.
  task automatic finish_cooldown(input int frames);
    for (int f = 1; f <= frames; f++) begin
      step($urandom_range(1, 3));
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL cooldown_busy frame=%0d busy=%b state=%0d exp busy=1", f, busy, st);
      end
      sof = 1'b1;
      step(1);
      sof = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL cooldown_last busy=%b state=%0d exp busy=1", busy, st);
    end
    step(1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL cooldown_release busy=%b state=%0d exp busy=0", busy, st);
    end
  endtask

  // One complete press-deploy-ack-cooldown (or denial) sequence.
  task automatic run_shot(input logic [N-1:0] pattern, input int ack_delay, input bit scramble);
    logic [N-1:0] exp_dep;
    exp_q.push_back(model_pick(pattern));
    act = pattern;
    press();
    exp_dep = exp_q.pop_front();
    checks++;
    if (deploy !== exp_dep) begin
      failures++;
      $display("FAIL deploy_slot act=%h got=%h exp=%h", pattern, deploy, exp_dep);
    end
    if (exp_dep == '0) begin
      checks++;
      if (denied !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL denied_pulse denied=%b busy=%b exp denied=1 busy=0", denied, busy);
      end
      step(1);
      checks++;
      if (denied !== 1'b0 || deploy !== '0) begin
        failures++;
        $display("FAIL denied_width denied=%b deploy=%h exp 0/0", denied, deploy);
      end
      return;
    end
    step(1);
    checks++;
    if (deploy !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL deploy_width deploy=%h busy=%b exp deploy=0 busy=1", deploy, busy);
    end
    for (int k = 0; k < ack_delay; k++) begin
      if (scramble) act = N'($urandom) & ~exp_dep;
      step(1);
      checks++;
      if (fired !== exp_fired || ack_error !== 1'b0) begin
        failures++;
        $display("FAIL early_ack k=%0d fired=%0d err=%b exp fired=%0d err=0", k, fired, ack_error, exp_fired);
      end
    end
    act = act | exp_dep;
    step(1);
    exp_fired = model_inc(exp_fired);
    checks++;
    if (fired !== exp_fired || busy !== 1'b1) begin
      failures++;
      $display("FAIL ack_count fired=%0d busy=%b exp fired=%0d busy=1", fired, busy, exp_fired);
    end
    finish_cooldown(CD);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetN = 1'b0;
    #2;
    checks++;
    if (deploy !== '0 || busy !== 1'b0 || denied !== 1'b0 || ack_error !== 1'b0 || fired !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs deploy=%h busy=%b denied=%b err=%b fired=%0d exp all 0",
               deploy, busy, denied, ack_error, fired);
    end
    checks++;
    if (deploy0 !== '0 || busy0 !== 1'b0 || fired0 !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs_nocd deploy=%h busy=%b fired=%0d exp all 0", deploy0, busy0, fired0);
    end
    step(2);
    resetN = 1'b1;
    exp_fired  = '0;
    exp_fired0 = '0;
    step(2);
  endtask

  task automatic test_single_shot();
    run_shot(8'h00, 1, 1'b0);
  endtask

  task automatic test_select_and_deny();
    run_shot(8'b1111_0111, 2, 1'b0);
    denied_cnt = 0;
    run_shot(8'hFF, 0, 1'b0);
    checks++;
    if (denied_cnt !== 1) begin
      failures++;
      $display("FAIL denied_count got=%0d exp=1", denied_cnt);
    end
  endtask

  task automatic test_random_shots();
    logic [N-1:0] pat;
    for (int it = 0; it < 20; it++) begin
      pat = N'($urandom);
      if ($urandom_range(0, 4) == 0) pat = '1;
      run_shot(pat, $urandom_range(0, TO - 2), 1'b1);
    end
  endtask

  task automatic test_hold();
    act = '0;
    deploy_cnt = 0;
    shoot = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      sof = ((cyc % 20) == 10);
      if (cyc == 4) act[0] = 1'b1;
      step(1);
    end
    sof = 1'b0;
    shoot = 1'b0;
    exp_fired = model_inc(exp_fired);
    step(30);
    checks++;
    if (deploy_cnt !== 1) begin
      failures++;
      $display("FAIL hold_single_deploy got=%0d exp=1", deploy_cnt);
    end
    checks++;
    if (busy !== 1'b0 || fired !== exp_fired) begin
      failures++;
      $display("FAIL hold_end busy=%b fired=%0d exp busy=0 fired=%0d", busy, fired, exp_fired);
    end
  endtask

  task automatic test_pending();
    logic [N-1:0] exp_dep;
    act = '0;
    deploy_cnt = 0;
    press();
    checks++;
    if (deploy !== 8'h01) begin
      failures++;
      $display("FAIL pend_first got=%h exp=01", deploy);
    end
    step(1);
    act[0] = 1'b1;
    step(1);
    exp_fired = model_inc(exp_fired);
    repeat (4) begin
      shoot = 1'b1;
      step(1);
      shoot = 1'b0;
      step(1);
    end
    checks++;
    if (deploy_cnt !== 1) begin
      failures++;
      $display("FAIL pend_in_cooldown deploys=%0d exp=1", deploy_cnt);
    end
    finish_cooldown(CD);
    checks++;
    if (deploy !== '0) begin
      failures++;
      $display("FAIL pend_not_early got=%h exp=00", deploy);
    end
    exp_dep = model_pick(act);
    step(1);
    checks++;
    if (deploy !== exp_dep || busy !== 1'b1) begin
      failures++;
      $display("FAIL pend_served got=%h busy=%b exp=%h busy=1", deploy, busy, exp_dep);
    end
    step(1);
    act = act | exp_dep;
    step(1);
    exp_fired = model_inc(exp_fired);
    finish_cooldown(CD);
    step(10);
    checks++;
    if (deploy_cnt !== 2 || fired !== exp_fired) begin
      failures++;
      $display("FAIL pend_total deploys=%0d fired=%0d exp deploys=2 fired=%0d", deploy_cnt, fired, exp_fired);
    end
  endtask

  task automatic test_enable_clears();
    act = '0;
    deploy_cnt = 0;
    press();
    step(1);
    act[0] = 1'b1;
    step(1);
    exp_fired = model_inc(exp_fired);
    shoot = 1'b1;
    step(1);
    shoot = 1'b0;
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    finish_cooldown(CD);
    step(10);
    checks++;
    if (deploy_cnt !== 1) begin
      failures++;
      $display("FAIL enable_drops_pending deploys=%0d exp=1", deploy_cnt);
    end
    enable = 1'b0;
    shoot = 1'b1;
    step(1);
    checks++;
    if (deploy !== '0 || denied !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL disabled_press deploy=%h denied=%b busy=%b exp 0/0/0", deploy, denied, busy);
    end
    shoot = 1'b0;
    step(1);
    enable = 1'b1;
    step(3);
    checks++;
    if (deploy_cnt !== 1) begin
      failures++;
      $display("FAIL disabled_total deploys=%0d exp=1", deploy_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] exp_dep;
    act = N'($urandom) & 8'h7F;
    exp_dep = model_pick(act);
    err_cnt = 0;
    press();
    checks++;
    if (deploy !== exp_dep) begin
      failures++;
      $display("FAIL to_deploy got=%h exp=%h", deploy, exp_dep);
    end
    for (int j = 1; j <= TO; j++) begin
      act = N'($urandom) & ~exp_dep;
      step(1);
      checks++;
      if (ack_error !== 1'b0) begin
        failures++;
        $display("FAIL to_early cycle=%0d err=%b exp=0", j, ack_error);
      end
    end
    step(1);
    checks++;
    if (ack_error !== 1'b1 || denied !== 1'b0 || fired !== exp_fired || busy !== 1'b1) begin
      failures++;
      $display("FAIL to_error err=%b denied=%b fired=%0d busy=%b exp err=1 denied=0 fired=%0d busy=1",
               ack_error, denied, fired, busy, exp_fired);
    end
    step(1);
    checks++;
    if (ack_error !== 1'b0) begin
      failures++;
      $display("FAIL to_width err=%b exp=0", ack_error);
    end
    finish_cooldown(CD);
    checks++;
    if (err_cnt !== 1 || fired !== exp_fired) begin
      failures++;
      $display("FAIL to_total errs=%0d fired=%0d exp errs=1 fired=%0d", err_cnt, fired, exp_fired);
    end
  endtask

  task automatic test_sof_on_entry();
    act = '0;
    press();
    step(1);
    act[0] = 1'b1;
    sof = 1'b1;
    step(1);
    sof = 1'b0;
    exp_fired = model_inc(exp_fired);
    checks++;
    if (fired !== exp_fired) begin
      failures++;
      $display("FAIL entry_ack fired=%0d exp=%0d", fired, exp_fired);
    end
    finish_cooldown(CD);
  endtask

  task automatic test_reset_midseq();
    act = '0;
    press();
    step(1);
    shoot = 1'b1;
    step(1);
    shoot = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    exp_fired  = '0;
    exp_fired0 = '0;
    checks++;
    if (deploy !== '0 || busy !== 1'b0 || denied !== 1'b0 || ack_error !== 1'b0 || fired !== exp_fired) begin
      failures++;
      $display("FAIL midreset_outputs deploy=%h busy=%b denied=%b err=%b fired=%0d exp all 0",
               deploy, busy, denied, ack_error, fired);
    end
    step(1);
    resetN = 1'b1;
    deploy_cnt = 0;
    err_cnt = 0;
    step(40);
    checks++;
    if (deploy_cnt !== 0 || err_cnt !== 0 || busy !== 1'b0 || fired !== exp_fired) begin
      failures++;
      $display("FAIL midreset_after deploys=%0d errs=%0d busy=%b fired=%0d exp 0/0/0/0",
               deploy_cnt, err_cnt, busy, fired);
    end
  endtask

  task automatic test_no_cooldown();
    logic [N-1:0] exp_dep;
    act0 = N'($urandom) & 8'h0F;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy0 !== 1'b0) begin
        failures++;
        $display("FAIL nocd_idle k=%0d busy=%b state=%0d exp busy=0", k, busy0, st0);
      end
      exp_dep = model_pick(act0);
      shoot0 = 1'b1;
      step(1);
      shoot0 = 1'b0;
      checks++;
      if (deploy0 !== exp_dep) begin
        failures++;
        $display("FAIL nocd_deploy k=%0d got=%h exp=%h", k, deploy0, exp_dep);
      end
      step(1);
      act0 = act0 | exp_dep;
      step(1);
      exp_fired0 = model_inc(exp_fired0);
      checks++;
      if (fired0 !== exp_fired0 || denied0 !== 1'b0 || err0 !== 1'b0) begin
        failures++;
        $display("FAIL nocd_ack k=%0d fired=%0d denied=%b err=%b exp fired=%0d 0/0",
                 k, fired0, denied0, err0, exp_fired0);
      end
      step(1);
      checks++;
      if (busy0 !== 1'b0) begin
        failures++;
        $display("FAIL nocd_release k=%0d busy=%b exp=0", k, busy0);
      end
      step(2);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    resetN = 1'b0;
    sof = 1'b0; shoot = 1'b0; enable = 1'b1; act = '0;
    sof0 = 1'b0; shoot0 = 1'b0; act0 = '0;
    test_reset();
    test_single_shot();
    test_select_and_deny();
    test_random_shots();
    test_hold();
    test_pending();
    test_enable_clears();
    test_timeout();
    test_sof_on_entry();
    test_reset_midseq();
    test_no_cooldown();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog sim time exceeded, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shot_scheduler.md
Name: shot_scheduler

Overview:
Sequences the shot pool (NUM_SHOTS shot engines). It turns the player's fire button into a single one-cycle deploy pulse, aimed at the lowest-index idle shot slot. It confirms that the slot went active, then enforces a frame-based fire cooldown. It sits between the key inputs and game_controller/shotLogic, and replaces direct deploy_shot generation.

Parameters:
NUM_SHOTS, 8, number of shot slots; width of the slot vectors.
COOLDOWN_FRAMES, 6, startOfFrame pulses between the end of one shot and the next shot being accepted; 0 = no cooldown.
ACK_TIMEOUT, 15, clk cycles to wait for the selected slot's isActive before giving up; range 1..255.

Ports:
clk  in  1  system clock (50 MHz)
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per VGA frame
shoot  in  1  fire button level, active-high, already synchronised
enable  in  1  gameplay enable; 0 = ignore presses
shots_active  in  NUM_SHOTS  per-slot isActive from shotLogic
deploy_shot  out  NUM_SHOTS  one-hot one-cycle deploy pulse
busy  out  1  high in every state except IDLE
denied  out  1  one-cycle pulse: press dropped because no slot is free
ack_error  out  1  one-cycle pulse: ACK_TIMEOUT expired
shots_fired  out  16  saturating count of acknowledged shots

Behaviour:
- Reset (async, resetN=0): state=IDLE; deploy_shot=0; busy=0; denied=0; ack_error=0; shots_fired=0; pending=0; shoot_q=0; slot register=0; counters=0. Reset mid-sequence aborts it; no deploy pulse is issued after release until a new press arrives.
- Edge detect: shoot_q is registered. press = shoot & ~shoot_q & enable. A held button gives exactly one press.
- Free-slot select (combinational): lowest index i with shots_active[i]=0. free_any = ~&shots_active.
- States:
  - IDLE:
    - press, or pending=1, with free_any → latch slot, clear pending → ISSUE.
    - press or pending with no free slot → denied pulse next cycle, clear pending, stay IDLE.
  - ISSUE (1 cycle): deploy_shot = one-hot(slot), registered. Load ack counter = ACK_TIMEOUT → WAIT_ACK.
  - WAIT_ACK:
    - shots_active[slot]=1 → shots_fired+1 (saturates at 16'hFFFF) → COOLDOWN.
    - Otherwise decrement the counter. At 0 → ack_error pulse → COOLDOWN. shots_fired is not incremented.
  - COOLDOWN:
    - On entry, load frame counter = COOLDOWN_FRAMES.
    - Each startOfFrame decrements it. A count of 0 → IDLE on the next cycle.
    - COOLDOWN_FRAMES=0 → IDLE one cycle after entry.
- Latency: press seen at cycle N in IDLE → deploy_shot high at cycle N+1, for exactly one cycle.
- Pending: a press in ISSUE, WAIT_ACK or COOLDOWN sets pending (one-deep; further presses are lost). Pending is served on the first IDLE cycle.
- enable=0: press is suppressed and pending is cleared. An in-flight sequence runs to completion.
- Slot freeing during WAIT_ACK does not change the latched slot. Only shots_active[slot] counts as the acknowledgement.
- startOfFrame coincident with COOLDOWN entry does not decrement; the load wins.
- deploy_shot is always one-hot or zero. Never more than one shot in flight per sequence.
- Assertions:
  - $onehot0(deploy_shot).
  - deploy_shot≠0 only in ISSUE.
  - denied and ack_error are never both high.

Test Plan:
1. Reset, shots_active=8'h00, single shoot press at cycle N → deploy_shot=8'h01 at N+1 only. Drive shots_active[0]=1 at N+3 → shots_fired=1; busy stays high until 6 startOfFrame pulses have passed.
2. shots_active=8'b1111_0111, press → deploy_shot=8'h08. shots_active=8'hFF, press in IDLE → denied=1 for one cycle, no deploy, busy=0.
3. Hold shoot high for 1000 cycles → exactly one deploy pulse; pending stays 0.
4. Press during COOLDOWN, then three more presses → exactly one extra deploy, issued on the first IDLE cycle after cooldown.
5. Never assert the shots_active bit after deploy → ack_error after 15 WAIT_ACK cycles, shots_fired unchanged, cooldown still enforced.
6. Assert resetN=0 in WAIT_ACK, then release → all outputs 0, state IDLE. A pending press taken before reset is not served. COOLDOWN_FRAMES=0 build: back-to-back presses spaced 4 cycles after ack → each deploys.
